// File: rtl/spiker_adapter_reg_pkg.sv
// Shared types and default sizing for the spiker adapter result path.
// The result reader imports this package, and so does its bench.
package spiker_adapter_reg_pkg;

  localparam int RR_WIDTH   = 32;
  localparam int RR_N_OUT   = 10;
  localparam int RR_COUNT_W = 8;
  localparam int RR_STEP_W  = 16;
  localparam int N_RES_REG  = (RR_N_OUT * RR_COUNT_W + RR_WIDTH - 1) / RR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCUM     = 2'd1,
    ST_WRITEBACK = 2'd2
  } rr_state_e;

  typedef logic [RR_N_OUT-1:0][RR_COUNT_W-1:0] cnt_vec_t;

endpackage

// File: rtl/spiker_spike_counter.sv
// Bank of per-neuron saturating spike counters with a synchronous clear.
// A counter that has reached its maximum value holds there and does not wrap.
module spiker_spike_counter #(
  parameter int N_OUT   = 10,
  parameter int COUNT_W = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clr_i,
  input  logic                            en_i,
  input  logic [N_OUT-1:0]                spk_i,
  output logic [N_OUT-1:0][COUNT_W-1:0]   cnt_o
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (spk_i[k] && (cnt_o[k] != CNT_MAX)) begin
          cnt_o[k] <= cnt_o[k] + COUNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/spiker_result_reader.sv
// Accumulates per-neuron spike counts over a programmed number of time steps,
// then writes the packed counts into the result registers and raises an interrupt.
module spiker_result_reader
  import spiker_adapter_reg_pkg::*;
#(
  parameter int WIDTH   = RR_WIDTH,
  parameter int N_OUT   = RR_N_OUT,
  parameter int COUNT_W = RR_COUNT_W,
  parameter int STEP_W  = RR_STEP_W,
  localparam int NRES   = (N_OUT * COUNT_W + WIDTH - 1) / WIDTH,
  localparam int IDX_W  = (NRES > 1) ? $clog2(NRES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [STEP_W-1:0] n_steps_i,
  input  logic [N_OUT-1:0]  spk_i,
  input  logic              spk_valid_i,
  output logic              spk_ready_o,
  output logic [WIDTH-1:0]  res_d_o,
  output logic              res_de_o,
  output logic [IDX_W-1:0]  res_idx_o,
  output logic              busy_o,
  output logic              irq_o,
  input  logic              irq_clr_i
);

  rr_state_e                   state;
  logic [STEP_W-1:0]           steps_tgt;
  logic [STEP_W-1:0]           steps_seen;
  logic [STEP_W-1:0]           steps_nxt;
  logic [IDX_W-1:0]            wr_idx;
  logic                        beat;
  logic                        cnt_clr;
  logic                        last_wr;
  logic [N_OUT-1:0][COUNT_W-1:0] cnt;
  logic [NRES*WIDTH-1:0]       packed_cnt;

  assign spk_ready_o = (state == ST_ACCUM);
  assign busy_o      = (state != ST_IDLE);
  assign beat        = spk_valid_i & spk_ready_o;
  assign cnt_clr     = (state == ST_IDLE) & start_i;
  assign steps_nxt   = steps_seen + STEP_W'(1);
  assign last_wr     = (state == ST_WRITEBACK) && (wr_idx == IDX_W'(NRES - 1));

  spiker_spike_counter #(
    .N_OUT   (N_OUT),
    .COUNT_W (COUNT_W)
  ) u_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (beat),
    .spk_i  (spk_i),
    .cnt_o  (cnt)
  );

  // Counts laid end to end: neuron k lands at flat bit k*COUNT_W, so register r
  // is simply slice r of the zero-extended vector.
  always_comb begin
    packed_cnt = '0;
    packed_cnt[N_OUT*COUNT_W-1:0] = cnt;
  end

  always_comb begin
    res_de_o  = 1'b0;
    res_idx_o = '0;
    res_d_o   = '0;
    if (state == ST_WRITEBACK) begin
      res_de_o  = 1'b1;
      res_idx_o = wr_idx;
      res_d_o   = packed_cnt[WIDTH*32'(wr_idx) +: WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      steps_tgt  <= '0;
      steps_seen <= '0;
      wr_idx     <= '0;
      irq_o      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            steps_tgt  <= n_steps_i;
            steps_seen <= '0;
            wr_idx     <= '0;
            state      <= (n_steps_i == '0) ? ST_WRITEBACK : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            steps_seen <= steps_nxt;
            if (steps_nxt == steps_tgt) state <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          if (last_wr) begin
            wr_idx <= '0;
            state  <= ST_IDLE;
          end else begin
            wr_idx <= wr_idx + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A completion in the same cycle as a clear leaves the interrupt set.
      if (last_wr)        irq_o <= 1'b1;
      else if (irq_clr_i) irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spiker_result_reader.sv
// Bench for spiker_result_reader: randomized runs against a count-per-neuron model,
// plus directed saturation, zero-step, race and mid-run reset cases.
module tb_spiker_result_reader;
  import spiker_adapter_reg_pkg::*;

  localparam int WIDTH   = RR_WIDTH;
  localparam int N_OUT   = RR_N_OUT;
  localparam int COUNT_W = RR_COUNT_W;
  localparam int STEP_W  = RR_STEP_W;
  localparam int NRES    = N_RES_REG;
  localparam int IDX_W   = (NRES > 1) ? $clog2(NRES) : 1;
  localparam int CMAX    = (1 << COUNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [STEP_W-1:0] n_steps_i = '0;
  logic [N_OUT-1:0]  spk_i = '0;
  logic              spk_valid_i = 1'b0;
  logic              spk_ready_o;
  logic [WIDTH-1:0]  res_d_o;
  logic              res_de_o;
  logic [IDX_W-1:0]  res_idx_o;
  logic              busy_o;
  logic              irq_o;
  logic              irq_clr_i = 1'b0;

  always #5 clk_i = ~clk_i;

  spiker_result_reader dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .n_steps_i   (n_steps_i),
    .spk_i       (spk_i),
    .spk_valid_i (spk_valid_i),
    .spk_ready_o (spk_ready_o),
    .res_d_o     (res_d_o),
    .res_de_o    (res_de_o),
    .res_idx_o   (res_idx_o),
    .busy_o      (busy_o),
    .irq_o       (irq_o),
    .irq_clr_i   (irq_clr_i)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fails  = 0;
  int de_seen  = 0;
  int de_exp   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_res[NRES];
  int  model_cnt[N_OUT];
  bit  model_irq = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each result register holds whole counts, neuron k in register
  // (k*COUNT_W)/WIDTH at bit (k*COUNT_W)%WIDTH.
  task automatic push_expected();
    for (int r = 0; r < NRES; r++) begin
      logic [WIDTH-1:0] v;
      v = '0;
      for (int k = 0; k < N_OUT; k++)
        if ((k * COUNT_W) / WIDTH == r)
          v = v | (WIDTH'(model_cnt[k]) << ((k * COUNT_W) % WIDTH));
      exp_q.push_back(v);
    end
    de_exp += NRES;
  endtask

  // Outside write-back the result bus must read zero.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (res_de_o) de_seen++;
      else check_eq("idle_bus", {res_d_o, 30'd0, res_idx_o}, 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [N_OUT-1:0] pick_spk(input int mode, input int beat);
    logic [N_OUT-1:0] s;
    case (mode)
      1:       s = '1;
      2: begin
        s = '0;
        s[3] = 1'b1;
        if (beat < 2) s[9] = 1'b1;
      end
      default: s = N_OUT'($urandom);
    endcase
    return s;
  endfunction

  task automatic run_case(input int n, input int p_valid, input int mode,
                          input bit poke_start, input bit clr_at_end);
    int beats;
    int budget;
    for (int k = 0; k < N_OUT; k++) model_cnt[k] = 0;
    spk_valid_i = 1'b1;
    spk_i       = '1;
    start_i     = 1'b1;
    n_steps_i   = STEP_W'(n);
    cyc();
    start_i = 1'b0;
    if (n == 0) push_expected();
    beats  = 0;
    budget = 0;
    while (beats < n) begin
      if (budget > 5000) begin
        check_eq("beat_timeout", 64'(beats), 64'(n));
        return;
      end
      budget++;
      start_i     = poke_start && (budget == 1);
      n_steps_i   = poke_start ? STEP_W'(7) : STEP_W'(n);
      spk_valid_i = ($urandom_range(99) < 32'(p_valid));
      spk_i       = pick_spk(mode, beats);
      @(negedge clk_i);
      check_eq("accum_ready", spk_ready_o, 1);
      check_eq("accum_busy", busy_o, 1);
      if (spk_valid_i && spk_ready_o) begin
        for (int k = 0; k < N_OUT; k++)
          if (spk_i[k] && model_cnt[k] < CMAX) model_cnt[k]++;
        beats++;
        if (beats == n) push_expected();
      end
      if (beats < n) cyc();
    end
    if (n > 0) cyc();
    start_i     = 1'b0;
    spk_valid_i = 1'b1;
    for (int i = 0; i < NRES; i++) begin
      logic [WIDTH-1:0] e;
      @(negedge clk_i);
      check_eq("wb_de", res_de_o, 1);
      check_eq("wb_idx", 64'(res_idx_o), 64'(i));
      check_eq("wb_q_nonempty", exp_q.size() > 0, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_eq("wb_data", res_d_o, e);
      last_res[i] = res_d_o;
      check_eq("wb_ready", spk_ready_o, 0);
      check_eq("wb_busy", busy_o, 1);
      check_eq("wb_irq_before", irq_o, model_irq);
      if (clr_at_end && i == NRES - 1) irq_clr_i = 1'b1;
      cyc();
    end
    irq_clr_i   = 1'b0;
    spk_valid_i = 1'b0;
    model_irq   = 1'b1;
    @(negedge clk_i);
    check_eq("done_irq", irq_o, 1);
    check_eq("done_busy", busy_o, 0);
    check_eq("done_de", res_de_o, 0);
    cyc();
  endtask

  task automatic clear_irq();
    irq_clr_i = 1'b1;
    cyc();
    irq_clr_i = 1'b0;
    model_irq = 1'b0;
    @(negedge clk_i);
    check_eq("irq_cleared", irq_o, 0);
    cyc();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, spk_ready_o, 0);
    check_eq({tag, "_de"}, res_de_o, 0);
    check_eq({tag, "_d"}, res_d_o, 0);
    check_eq({tag, "_idx"}, 64'(res_idx_o), 0);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_irq"}, irq_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_ni = 1'b1;
    cyc();

    // basic pattern
    run_case(4, 100, 2, 1'b0, 1'b0);
    check_eq("basic_reg0", last_res[0], 32'h0400_0000);
    check_eq("basic_reg1", last_res[1], 32'h0000_0000);
    check_eq("basic_reg2", last_res[2], 32'h0000_0200);
    clear_irq();

    // saturation
    run_case(300, 100, 1, 1'b0, 1'b0);
    check_eq("sat_reg0", last_res[0], 32'hFFFF_FFFF);
    check_eq("sat_reg1", last_res[1], 32'hFFFF_FFFF);
    check_eq("sat_reg2", last_res[2], 32'h0000_FFFF);

    // zero steps with valid held high; irq from the previous run still pending
    run_case(0, 100, 1, 1'b0, 1'b0);
    check_eq("zero_reg1", last_res[1], 32'h0);
    clear_irq();

    // randomized backpressure runs
    for (int t = 0; t < 8; t++)
      run_case($urandom_range(1, 20), $urandom_range(20, 90), 0, 1'b0, 1'b0);
    clear_irq();

    // start during ACCUM ignored, clear coincident with completion
    run_case(6, 60, 0, 1'b1, 1'b1);
    clear_irq();

    // reset mid-ACCUM after 2 of 5 beats
    for (int k = 0; k < N_OUT; k++) model_cnt[k] = 0;
    start_i = 1'b1;
    n_steps_i = STEP_W'(5);
    cyc();
    start_i = 1'b0;
    spk_valid_i = 1'b1;
    spk_i = '1;
    repeat (2) cyc();
    rst_ni = 1'b0;
    #1;
    check_all_zero("midreset");
    spk_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
    run_case(1, 100, 0, 1'b0, 1'b0);
    clear_irq();

    repeat (3) cyc();
    check_eq("de_total", 64'(de_seen), 64'(de_exp));
    check_eq("queue_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
